w_schedule_sequencer: RTL and testbench

//  Drives the SHA-256 message-expansion controller: generates its 5-bit count phase

---
 rtl/w_schedule_sequencer_if.sv | 34 +++
 rtl/w_schedule_sequencer.sv | 137 +++++++++++++
 tb/tb_w_schedule_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/w_schedule_sequencer_if.sv
// w_schedule_sequencer_if
// Bundles the signals between the SHA-256 message-schedule sequencer and the
// expansion controller / W RAM pair.
//   msg_valid       : pulse, a new 512-bit block is ready; begin a schedule
//   hold            : stall from the downstream W consumer; freezes the sequencer
//   data1_from_ram  : RAM port 1 read data (1-cycle synchronous read)
//   data2_from_ram  : RAM port 2 read data (1-cycle synchronous read)
//   count           : 5-bit phase driven to the controller
//   final_sum       : expanded word returned to the controller for write-back
//   round           : index t of the word currently being produced
//   busy            : schedule in progress
//   done            : one-cycle pulse after the last word is presented
// The master modport is the controller/RAM side; the slave modport is the sequencer.
interface w_schedule_sequencer_if;
   logic        msg_valid;
   logic        hold;
   logic [31:0] data1_from_ram;
   logic [31:0] data2_from_ram;
   logic [4:0]  count;
   logic [31:0] final_sum;
   logic [5:0]  round;
   logic        busy;
   logic        done;

   modport master (
      output msg_valid, hold, data1_from_ram, data2_from_ram,
      input  count, final_sum, round, busy, done
   );

   modport slave (
      input  msg_valid, hold, data1_from_ram, data2_from_ram,
      output count, final_sum, round, busy, done
   );
endinterface

// File: rtl/w_schedule_sequencer.sv
// w_schedule_sequencer
// Sequences the SHA-256 message-expansion controller. It walks the controller
// through LOAD_WORDS load phases and then six phases per expanded word, and
// computes final_sum = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] from the two
// RAM read ports so the controller can write it back.
// Ports:
//   clk   : rising-edge clock
//   start : synchronous active-high reset (wins over hold and msg_valid)
//   bus   : slave side of w_schedule_sequencer_if (handshake, RAM data, phase,
//           result, round index, busy, done)
module w_schedule_sequencer #(
   parameter int LOAD_WORDS = 16,
   parameter int NUM_ROUNDS = 64,
   parameter int PARK_COUNT = 31
) (
   input logic                    clk,
   input logic                    start,
   w_schedule_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, LOAD, EXPAND, FIN} state_t;

   // Phase numbers of one expansion word: 16 starts the word, 18 and 19 carry
   // the RAM operands, 21 is where the controller latches W.
   localparam logic [4:0] PH_FIRST   = 5'd16;
   localparam logic [4:0] PH_SIGMA   = 5'd18;
   localparam logic [4:0] PH_SUM     = 5'd19;
   localparam logic [4:0] PH_LAST    = 5'd21;
   localparam logic [4:0] PARK       = 5'(PARK_COUNT);
   localparam logic [4:0] LOAD_LAST  = 5'(LOAD_WORDS - 1);
   localparam logic [5:0] ROUND_LOAD = 6'(LOAD_WORDS);
   localparam logic [5:0] ROUND_LAST = 6'(NUM_ROUNDS - 1);

   state_t      state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [5:0]  round_q, round_d;
   logic [31:0] partial_q, partial_d;
   logic [31:0] finalSum_q, finalSum_d;

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   // State and datapath registers. start acts as a synchronous reset that
   // parks the controller and aborts any schedule in flight.
   always_ff @(posedge clk) begin
      if (start) begin
         state_q    <= IDLE;
         count_q    <= PARK;
         round_q    <= '0;
         partial_q  <= '0;
         finalSum_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         round_q    <= round_d;
         partial_q  <= partial_d;
         finalSum_q <= finalSum_d;
      end
   end

   // Next-state logic. Everything holds by default, so a stall simply skips
   // the case statement. The RAM data is only looked at in phases 18 and 19;
   // in every other phase it cannot reach any register.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      round_d    = round_q;
      partial_d  = partial_q;
      finalSum_d = finalSum_q;
      if (!bus.hold) begin
         case (state_q)
            IDLE: begin
               count_d = PARK;
               if (bus.msg_valid) begin
                  state_d = LOAD;
                  count_d = '0;
                  round_d = '0;
               end
            end
            LOAD: begin
               if (count_q == LOAD_LAST) begin
                  state_d = EXPAND;
                  count_d = PH_FIRST;
                  round_d = ROUND_LOAD;
               end else begin
                  count_d = count_q + 5'd1;
                  round_d = {1'b0, count_q + 5'd1};
               end
            end
            EXPAND: begin
               case (count_q)
                  PH_SIGMA: partial_d = sigma0(bus.data1_from_ram) + sigma1(bus.data2_from_ram);
                  PH_SUM:   finalSum_d = partial_q + bus.data1_from_ram + bus.data2_from_ram;
                  default:  ;
               endcase
               if (count_q == PH_LAST) begin
                  if (round_q == ROUND_LAST) begin
                     state_d = FIN;
                     count_d = PARK;
                     round_d = '0;
                  end else begin
                     count_d = PH_FIRST;
                     round_d = round_q + 6'd1;
                  end
               end else begin
                  count_d = count_q + 5'd1;
               end
            end
            FIN: begin
               state_d = IDLE;
               count_d = PARK;
            end
            default: begin
               state_d = IDLE;
               count_d = PARK;
            end
         endcase
      end
   end

   // Outputs come straight from the registers. done is qualified with hold so
   // a stalled FIN cycle never shows a pulse; the pulse appears on the first
   // unstalled FIN cycle, which is also the one that leaves FIN.
   always_comb begin
      bus.count     = count_q;
      bus.round     = round_q;
      bus.final_sum = finalSum_q;
      bus.busy      = (state_q == LOAD) || (state_q == EXPAND);
      bus.done      = (state_q == FIN) && !bus.hold;
   end

endmodule

// File: tb/tb_w_schedule_sequencer.sv
// tb_w_schedule_sequencer
// Self-checking bench for w_schedule_sequencer. A behavioural model holds the
// expected phase/round sequence of a whole schedule in a queue and the full
// W[0..63] schedule computed directly from the message block; a RAM model feeds
// the sequencer the operands it asks for, and a compare process checks every
// output on every cycle.
module tb_w_schedule_sequencer;

   typedef struct {
      int cnt;
      int rnd;
      bit busy;
      bit fin;
   } entry_t;

   logic clk = 1'b0;
   logic start;

   w_schedule_sequencer_if busIf ();

   w_schedule_sequencer dut (
      .clk   (clk),
      .start (start),
      .bus   (busIf)
   );

   always #5 clk = ~clk;

   int          totalChecks = 0;
   int          badChecks = 0;
   int          cycleCount = 0;
   int          acceptCyc = 0;
   bit          checkEnable = 1'b0;
   bit          latencyArmed = 1'b0;
   bit          wrapMode = 1'b0;
   logic [31:0] msgW [16];
   logic [31:0] goldW [64];
   logic [31:0] expFinal = '0;
   logic [31:0] wrapVal;
   entry_t      cur = '{cnt: 31, rnd: 0, busy: 1'b0, fin: 1'b0};
   entry_t      expQ [$];

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Full SHA-256 message schedule straight from the message block.
   task automatic computeSchedule();
      for (int t = 0; t < 64; t++) begin
         if (t < 16) goldW[t] = msgW[t];
         else goldW[t] = sig1(goldW[t-2]) + goldW[t-7] + sig0(goldW[t-15]) + goldW[t-16];
      end
   endtask

   // Behavioural model: on each edge either reset, stall, step through the
   // precomputed phase list of the current schedule, or accept a new block.
   // The expected final_sum changes only at the end of phase 19.
   always @(posedge clk) begin
      cycleCount++;
      if (start) begin
         expQ.delete();
         cur = '{cnt: 31, rnd: 0, busy: 1'b0, fin: 1'b0};
         expFinal = '0;
      end else if (!busIf.hold) begin
         if (cur.cnt == 19) expFinal = wrapMode ? wrapVal : goldW[cur.rnd];
         if (expQ.size() > 0) begin
            cur = expQ.pop_front();
         end else if (!cur.busy && !cur.fin && busIf.msg_valid) begin
            for (int c = 0; c < 16; c++) expQ.push_back('{cnt: c, rnd: c, busy: 1'b1, fin: 1'b0});
            for (int t = 16; t < 64; t++)
               for (int p = 16; p <= 21; p++) expQ.push_back('{cnt: p, rnd: t, busy: 1'b1, fin: 1'b0});
            expQ.push_back('{cnt: 31, rnd: 0, busy: 1'b0, fin: 1'b1});
            cur = expQ.pop_front();
            acceptCyc = cycleCount;
         end else begin
            cur = '{cnt: 31, rnd: 0, busy: 1'b0, fin: 1'b0};
         end
      end
   end

   // RAM model: operands for phases 18/19 of the model's current word, random
   // junk in every other phase.
   always @(posedge clk) begin
      #1;
      if (cur.cnt == 18) begin
         busIf.data1_from_ram = wrapMode ? 32'hFFFF_FFFF : goldW[cur.rnd-15];
         busIf.data2_from_ram = wrapMode ? 32'hFFFF_FFFF : goldW[cur.rnd-2];
      end else if (cur.cnt == 19) begin
         busIf.data1_from_ram = wrapMode ? 32'hFFFF_FFFF : goldW[cur.rnd-16];
         busIf.data2_from_ram = wrapMode ? 32'hFFFF_FFFF : goldW[cur.rnd-7];
      end else begin
         busIf.data1_from_ram = $urandom;
         busIf.data2_from_ram = $urandom;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (checkEnable) begin
         checkOutput("count", 32'(busIf.count), 32'(cur.cnt));
         checkOutput("round", 32'(busIf.round), 32'(cur.rnd));
         checkOutput("busy", 32'(busIf.busy), 32'(cur.busy));
         checkOutput("done", 32'(busIf.done), 32'(cur.fin && !busIf.hold));
         checkOutput("final_sum", busIf.final_sum, expFinal);
         if (latencyArmed && busIf.done) begin
            // msg_valid cycle and done cycle both counted
            checkOutput("latency", 32'(cycleCount - acceptCyc + 2), 32'd306);
            latencyArmed = 1'b0;
         end
      end
   end

   task automatic applyStimulus(input logic startV, input logic msgV, input logic holdV);
      @(posedge clk);
      #1;
      start           = startV;
      busIf.msg_valid = msgV;
      busIf.hold      = holdV;
   endtask

   // Steps cycles with optional msg_valid noise (only while busy) and random
   // hold until the model reaches the requested phase/round.
   task automatic waitFor(input int cnt, input int rnd, input bit noise, input bit holdRand);
      bit found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         @(posedge clk);
         #1;
         busIf.msg_valid = noise && cur.busy && ($urandom_range(0, 3) == 0);
         busIf.hold      = holdRand && ($urandom_range(0, 5) == 0);
         if (cur.cnt == cnt && cur.rnd == rnd) found = 1'b1;
      end
      if (!found) checkOutput($sformatf("reach phase %0d round %0d", cnt, rnd), 32'd0, 32'd1);
   endtask

   task automatic waitIdle(input bit noise, input bit holdRand);
      bit found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         @(posedge clk);
         #1;
         busIf.msg_valid = noise && cur.busy && ($urandom_range(0, 3) == 0);
         busIf.hold      = holdRand && ($urandom_range(0, 5) == 0);
         if (!cur.busy && !cur.fin) found = 1'b1;
      end
      busIf.msg_valid = 1'b0;
      busIf.hold      = 1'b0;
      if (!found) checkOutput("return to idle", 32'd0, 32'd1);
      if (latencyArmed) begin
         checkOutput("done seen", 32'd0, 32'd1);
         latencyArmed = 1'b0;
      end
   endtask

   initial begin
      start           = 1'b1;
      busIf.msg_valid = 1'b0;
      busIf.hold      = 1'b0;
      wrapVal = sig1(32'hFFFF_FFFF) + 32'hFFFF_FFFF + sig0(32'hFFFF_FFFF) + 32'hFFFF_FFFF;
      checkOutput("model wrap", wrapVal, 32'h203F_FFFC);

      // Reset held for two cycles
      @(posedge clk);
      #1;
      checkEnable = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset count", 32'(busIf.count), 32'd31);
      checkOutput("reset final_sum", busIf.final_sum, 32'd0);
      checkOutput("reset busy", 32'(busIf.busy), 32'd0);
      checkOutput("reset done", 32'(busIf.done), 32'd0);
      checkOutput("reset round", 32'(busIf.round), 32'd0);
      start = 1'b0;

      // "abc" block, no stalls, full schedule with latency check
      for (int i = 0; i < 16; i++) msgW[i] = '0;
      msgW[0]  = 32'h6162_6380;
      msgW[15] = 32'h0000_0018;
      computeSchedule();
      checkOutput("model W16", goldW[16], 32'h6162_6380);
      checkOutput("model W17", goldW[17], 32'h000F_0000);
      latencyArmed = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitFor(20, 16, 1'b0, 1'b0);
      checkOutput("abc W16", busIf.final_sum, 32'h6162_6380);
      waitFor(20, 17, 1'b0, 1'b0);
      checkOutput("abc W17", busIf.final_sum, 32'h000F_0000);
      waitIdle(1'b0, 1'b0);

      // All-ones operands: carries out of bit 31 must be dropped
      wrapMode = 1'b1;
      latencyArmed = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitFor(20, 16, 1'b1, 1'b0);
      checkOutput("wrap sum", busIf.final_sum, 32'h203F_FFFC);
      waitIdle(1'b1, 1'b0);
      wrapMode = 1'b0;

      // Random block: 5-cycle stall at phase 19 of round 30, then abort at round 40
      for (int i = 0; i < 16; i++) msgW[i] = $urandom;
      computeSchedule();
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitFor(19, 30, 1'b1, 1'b0);
      busIf.msg_valid = 1'b0;
      busIf.hold      = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         busIf.hold = 1'b1;
      end
      @(posedge clk);
      #1;
      busIf.hold = 1'b0;
      checkOutput("hold count", 32'(busIf.count), 32'd19);
      checkOutput("hold round", 32'(busIf.round), 32'd30);
      waitFor(20, 30, 1'b1, 1'b0);
      checkOutput("W30 after hold", busIf.final_sum, goldW[30]);
      waitFor(20, 40, 1'b1, 1'b0);
      start           = 1'b1;
      busIf.msg_valid = 1'b0;
      busIf.hold      = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("abort count", 32'(busIf.count), 32'd31);
      checkOutput("abort busy", 32'(busIf.busy), 32'd0);
      checkOutput("abort done", 32'(busIf.done), 32'd0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

      // Fresh random block after the abort, with random stalls and msg_valid noise
      for (int i = 0; i < 16; i++) msgW[i] = $urandom;
      computeSchedule();
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitIdle(1'b1, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
